// File: rtl/code_pkg.sv
// Shared definitions for the code-word encoder and any decoder-side benches.
// Field widths, packed code type and a reference packing helper.
package code_pkg;

    localparam int OP_SIZE      = 4;
    localparam int PARAM_A_SIZE = 4;
    localparam int PARAM_B_SIZE = 4;
    localparam int COST_SIZE    = PARAM_A_SIZE + PARAM_B_SIZE;
    localparam int CODE_W       = OP_SIZE + PARAM_A_SIZE + PARAM_B_SIZE;
    localparam int FIFO_DEPTH   = 4;

    typedef logic [CODE_W-1:0] code_t;

    // Selects which parameter layout occupies the low bits of the code word.
    typedef enum logic {
        PACK_NARROW = 1'b0,
        PACK_WIDE   = 1'b1
    } pack_mode_e;

    function automatic code_t pack_code(
        input logic [OP_SIZE-1:0]      op,
        input logic                    wide,
        input logic [PARAM_A_SIZE-1:0] a,
        input logic [PARAM_B_SIZE-1:0] b,
        input logic [COST_SIZE-1:0]    cost
    );
        code_t word;
        if (pack_mode_e'(wide) == PACK_WIDE) begin
            word = {op, cost};
        end else begin
            word = {op, a, b};
        end
        return word;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO holding packed code words between the encoder and issuer.
// Occupancy counter disambiguates full from empty; pointers wrap naturally.
module code_fifo
    import code_pkg::*;
#(
    parameter int WIDTH = CODE_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == DEPTH_CNT);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rd_data = mem[rd_ptr];

    // Guard here too so the FIFO stays consistent even if a caller ignores full/empty.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/code_emit.sv
// Instruction encoder/issuer: packs decoded fields into code words, queues them and
// presents each popped word on a held register with a one-cycle strobe.
module code_emit
    import code_pkg::*;
#(
    parameter int OP_SIZE      = code_pkg::OP_SIZE,
    parameter int PARAM_A_SIZE = code_pkg::PARAM_A_SIZE,
    parameter int PARAM_B_SIZE = code_pkg::PARAM_B_SIZE,
    parameter int DEPTH        = code_pkg::FIFO_DEPTH,
    localparam int CODE_W      = OP_SIZE + PARAM_A_SIZE + PARAM_B_SIZE,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [OP_SIZE-1:0]                   in_op,
    input  logic                                 in_wide,
    input  logic [PARAM_A_SIZE-1:0]              in_act_type,
    input  logic [PARAM_B_SIZE-1:0]              in_dense_type,
    input  logic [PARAM_A_SIZE+PARAM_B_SIZE-1:0] in_cost_type,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CODE_W-1:0]                    out_code,
    output logic [CODE_W-1:0]                    issued_code,
    output logic                                 issued_strobe,
    output logic [CNT_W-1:0]                     count
);

    logic [CODE_W-1:0] packed_code;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;

    // Layout must remain the exact inverse of the decoder's field extraction.
    always_comb begin
        packed_code = '0;
        if (pack_mode_e'(in_wide) == PACK_WIDE) begin
            packed_code = {in_op, in_cost_type};
        end else begin
            packed_code = {in_op, in_act_type, in_dense_type};
        end
    end

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    code_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (packed_code),
        .rd_data (out_code),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // The strobe follows every pop by one cycle so a decoder can clock on it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_code   <= '0;
            issued_strobe <= 1'b0;
        end else begin
            issued_strobe <= pop;
            if (pop) begin
                issued_code <= out_code;
            end
        end
    end

endmodule
